// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 timing constants and the power-up init byte table.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam longint T_SETUP_NS = 64'sd60;
  localparam longint T_E_NS     = 64'sd480;
  localparam longint T_HOLD_NS  = 64'sd60;
  localparam longint T_EXEC_US  = 64'sd40;
  localparam longint T_LONG_US  = 64'sd1640;

  localparam int         INIT_LEN  = 6;
  localparam logic [2:0] INIT_LAST = 3'd5;
  localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  // ceil(t_ns * clk_hz / 1e9), never below one cycle
  function automatic longint ns_to_cycles(input longint t_ns, input longint clk_hz);
    longint cyc;
    cyc = (t_ns * clk_hz + 64'sd999_999_999) / 64'sd1_000_000_000;
    return (cyc < 64'sd1) ? 64'sd1 : cyc;
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    return (idx <= INIT_LAST) ? INIT_SEQ[idx] : 8'h00;
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done is high while the count is zero,
// so loading N-1 on entry to a state keeps that state for N cycles.
module lcd_delay_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_controller.sv
// HD44780 8-bit write-only controller: power-up wait, fixed init sequence, then one byte per request.
// A request is taken in one cycle from IDLE; req_ready stays low through SETUP/PULSE/HOLD/EXEC of that byte.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int POWERUP_US  = 40_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam longint CLK_HZ    = longint'(CLK_FREQ_HZ);
  localparam longint SETUP_CYC = ns_to_cycles(T_SETUP_NS, CLK_HZ);
  localparam longint E_CYC     = ns_to_cycles(T_E_NS, CLK_HZ);
  localparam longint HOLD_CYC  = ns_to_cycles(T_HOLD_NS, CLK_HZ);
  localparam longint EXEC_CYC  = ns_to_cycles(T_EXEC_US * 64'sd1000, CLK_HZ);
  localparam longint LONG_CYC  = ns_to_cycles(T_LONG_US * 64'sd1000, CLK_HZ);
  localparam longint PWR_CYC   = ns_to_cycles(longint'(POWERUP_US) * 64'sd1000, CLK_HZ);
  localparam longint MAX_CYC   = (PWR_CYC > LONG_CYC) ? PWR_CYC : LONG_CYC;
  localparam int     TW        = $clog2(MAX_CYC + 64'sd1);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 64'sd1);
  localparam logic [TW-1:0] E_LD     = TW'(E_CYC - 64'sd1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 64'sd1);
  localparam logic [TW-1:0] EXEC_LD  = TW'(EXEC_CYC - 64'sd1);
  localparam logic [TW-1:0] LONG_LD  = TW'(LONG_CYC - 64'sd1);
  // The arming cycle after reset counts as the first power-up cycle.
  localparam logic [TW-1:0] PWR_LD   = TW'(((PWR_CYC > 64'sd2) ? PWR_CYC : 64'sd2) - 64'sd2);

  lcd_state_e state_q, state_d;
  logic [2:0] init_idx_q, init_idx_d;
  logic       armed_q, armed_d;
  logic       init_done_q, init_done_d;
  logic       req_ready_q, req_ready_d;
  logic       lcd_e_q, lcd_e_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic [7:0] lcd_data_q, lcd_data_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  lcd_delay_counter #(
    .WIDTH (TW)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      PWR_WAIT: begin
        if (!armed_q) begin
          armed_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PWR_LD;
        end else if (tmr_done) begin
          state_d    = SETUP;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_byte(init_idx_q);
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d    = SETUP;
          lcd_rs_d   = req_rs;
          lcd_data_d = req_data;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = E_LD;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_d  = EXEC;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(lcd_rs_q, lcd_data_q) ? LONG_LD : EXEC_LD;
        end
      end
      EXEC: begin
        if (tmr_done) begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (init_idx_q == INIT_LAST) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d    = SETUP;
            init_idx_d = init_idx_q + 3'd1;
            lcd_rs_d   = 1'b0;
            lcd_data_d = init_byte(init_idx_q + 3'd1);
            tmr_load   = 1'b1;
            tmr_val    = SETUP_LD;
          end
        end
      end
      default: begin
        state_d = PWR_WAIT;
      end
    endcase

    lcd_e_d     = (state_d == PULSE);
    req_ready_d = (state_d == IDLE) && init_done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      init_idx_q  <= 3'd0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      req_ready_q <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      req_ready_q <= req_ready_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller at 25 MHz with a 100 us power-up wait (2500 cycles).
`timescale 1ns/1ps
module tb_lcd_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  lcd_controller #(
    .CLK_FREQ_HZ (25_000_000),
    .POWERUP_US  (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    repeat (4) step();
    total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL reset_lcd_e got=%b exp=0", lcd_e); end
    total++; if (lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_lcd_rs got=%b exp=0", lcd_rs); end
    total++; if (lcd_rw !== 1'b0) begin bad++; $display("FAIL reset_lcd_rw got=%b exp=0", lcd_rw); end
    total++; if (lcd_data !== 8'h00) begin bad++; $display("FAIL reset_lcd_data got=%h exp=00", lcd_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    rst_n = 1'b1;
    n = 0;
    while (lcd_e !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (n != 2502) begin bad++; $display("FAIL first_e_rise_delay got=%0d exp=2502", n); end
    total++; if (lcd_data !== 8'h38) begin bad++; $display("FAIL first_e_data got=%h exp=38", lcd_data); end
    total++; if (lcd_rs !== 1'b0) begin bad++; $display("FAIL first_e_rs got=%b exp=0", lcd_rs); end
  endtask

  // Entered with the first 0x38 pulse already high.
  task automatic test_init_sequence();
    logic [7:0] exp_seq [6];
    logic [7:0] got [6];
    logic       prev_e;
    int cnt, cyc, last_fall, gap, n, rs_bad;
    exp_seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) got[i] = 8'h00;
    got[0] = lcd_data; cnt = 1; prev_e = lcd_e;
    cyc = 0; last_fall = 0; gap = -1; rs_bad = 0;
    while (cnt < 6 && cyc < 50000) begin
      step(); cyc++;
      if (prev_e && !lcd_e) last_fall = cyc;
      if (!prev_e && lcd_e) begin
        if (cnt == 5) gap = cyc - last_fall;
        if (lcd_rs !== 1'b0) rs_bad++;
        got[cnt] = lcd_data;
        cnt++;
      end
      prev_e = lcd_e;
    end
    total++; if (cnt != 6) begin bad++; $display("FAIL init_pulse_count got=%0d exp=6", cnt); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL init_byte_%0d got=%h exp=%h", i, got[i], exp_seq[i]); end
    end
    total++; if (rs_bad != 0) begin bad++; $display("FAIL init_rs got=%0d nonzero exp=0", rs_bad); end
    total++; if (gap != 41004) begin bad++; $display("FAIL init_clear_gap got=%0d exp=41004", gap); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL init_done_early got=%b exp=0", init_done); end
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin step(); n++; end
    total++; if (n != 1014) begin bad++; $display("FAIL init_done_delay got=%0d exp=1014", n); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL init_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_single_write();
    int low_n, e_n, data_bad, extra_e;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL sw_ready_before got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
    step();
    req_valid = 1'b0; req_rs = 1'b0; req_data = 8'hFF;
    total++; if (lcd_rs !== 1'b1) begin bad++; $display("FAIL sw_rs got=%b exp=1", lcd_rs); end
    total++; if (lcd_data !== 8'h41) begin bad++; $display("FAIL sw_data got=%h exp=41", lcd_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sw_ready_drop got=%b exp=0", req_ready); end
    total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL sw_e_in_setup got=%b exp=0", lcd_e); end
    low_n = 1; e_n = 0; data_bad = 0;
    while (req_ready !== 1'b1 && low_n < 3000) begin
      if (low_n == 500) begin req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h77; end
      if (low_n == 510) req_valid = 1'b0;
      step();
      if (lcd_e === 1'b1) e_n++;
      if (lcd_rs !== 1'b1 || lcd_data !== 8'h41) data_bad++;
      if (req_ready !== 1'b1) low_n++;
    end
    total++; if (low_n != 1016) begin bad++; $display("FAIL sw_ready_low got=%0d exp=1016", low_n); end
    total++; if (e_n != 12) begin bad++; $display("FAIL sw_e_width got=%0d exp=12", e_n); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL sw_bus_stable got=%0d changes exp=0", data_bad); end
    extra_e = 0;
    repeat (20) begin
      step();
      if (lcd_e === 1'b1) extra_e++;
    end
    total++; if (extra_e != 0) begin bad++; $display("FAIL sw_ignored_req_pulse got=%0d exp=0", extra_e); end
    total++; if (lcd_data !== 8'h41) begin bad++; $display("FAIL sw_idle_hold got=%h exp=41", lcd_data); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL sw_ready_idle got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int acc, rises;
    int rise_cyc [2];
    logic [7:0] rb [2];
    logic prev_e, rdy_before;
    acc = 0; rises = 0; prev_e = lcd_e;
    rise_cyc[0] = 0; rise_cyc[1] = 0; rb[0] = 8'h00; rb[1] = 8'h00;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
    for (int c = 1; c <= 2100; c++) begin
      rdy_before = req_ready;
      step();
      if (rdy_before && req_valid) begin
        acc++;
        if (acc == 1) req_data = 8'h49;
        else begin req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00; end
      end
      if (!prev_e && lcd_e) begin
        if (rises < 2) begin rb[rises] = lcd_data; rise_cyc[rises] = c; end
        rises++;
      end
      prev_e = lcd_e;
    end
    req_valid = 1'b0;
    total++; if (acc != 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    total++; if (rises != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", rises); end
    total++; if (rb[0] !== 8'h48) begin bad++; $display("FAIL b2b_first_byte got=%h exp=48", rb[0]); end
    total++; if (rb[1] !== 8'h49) begin bad++; $display("FAIL b2b_second_byte got=%h exp=49", rb[1]); end
    total++;
    if (rise_cyc[1] - rise_cyc[0] != 1017) begin
      bad++; $display("FAIL b2b_rise_spacing got=%0d exp=1017", rise_cyc[1] - rise_cyc[0]);
    end
  endtask

  task automatic test_long_cmd();
    int low_n;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lc_ready_before got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h02;
    step();
    req_valid = 1'b0; req_data = 8'h00;
    total++; if (lcd_data !== 8'h02 || lcd_rs !== 1'b0) begin
      bad++; $display("FAIL lc_bus got=%b/%h exp=0/02", lcd_rs, lcd_data);
    end
    low_n = 1;
    while (req_ready !== 1'b1 && low_n < 45000) begin
      step();
      if (req_ready !== 1'b1) low_n++;
    end
    total++; if (low_n != 41016) begin bad++; $display("FAIL lc_ready_low got=%0d exp=41016", low_n); end
  endtask

  task automatic test_reset_in_pulse();
    int n;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    step();
    req_valid = 1'b0;
    n = 0;
    while (lcd_e !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (lcd_e !== 1'b1) begin bad++; $display("FAIL rp_pulse_seen got=%b exp=1", lcd_e); end
    repeat (5) step();
    rst_n = 1'b0;
    step();
    total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL rp_e_forced got=%b exp=0", lcd_e); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rp_init_done got=%b exp=0", init_done); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rp_req_ready got=%b exp=0", req_ready); end
    total++; if (lcd_data !== 8'h00) begin bad++; $display("FAIL rp_lcd_data got=%h exp=00", lcd_data); end
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    while (lcd_e !== 1'b1 && n < 3000) begin step(); n++; end
    total++; if (n != 2502) begin bad++; $display("FAIL rp_restart_delay got=%0d exp=2502", n); end
    total++; if (lcd_data !== 8'h38 || lcd_rs !== 1'b0) begin
      bad++; $display("FAIL rp_restart_byte got=%b/%h exp=0/38", lcd_rs, lcd_data);
    end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rp_init_done_after got=%b exp=0", init_done); end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_single_write();
    test_back_to_back();
    test_long_cmd();
    test_reset_in_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(40 * 110000);
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CLK_FREQ_HZ, default 25_000_000, is the clk frequency used for all timing derivation.
REQ-003 Parameter POWERUP_US, default 40_000, is the power-on wait before the first LCD write.
REQ-004 Port clk  in  1  system clock; all logic is on the rising edge.
REQ-005 Port rst_n  in  1  synchronous reset, active low.
REQ-006 Port req_valid  in  1  request present.
REQ-007 Port req_ready  out  1  controller accepts a request this cycle.
REQ-008 Port req_rs  in  1  0 means command byte, 1 means data byte.
REQ-009 Port req_data  in  8  byte to write.
REQ-010 Port init_done  out  1  power-up init sequence is complete.
REQ-011 Port lcd_rs  out  1  HD44780 RS.
REQ-012 Port lcd_rw  out  1  HD44780 RW; constant 0 (write-only).
REQ-013 Port lcd_e  out  1  HD44780 enable strobe.
REQ-014 Port lcd_data  out  8  HD44780 DB7..DB0, 8-bit mode.

Function
REQ-015 Derived cycle counts SHALL use ceil(t*CLK_FREQ_HZ/1e9), minimum 1.
- SETUP_CYC = 60 ns
- E_CYC = 480 ns
- HOLD_CYC = 60 ns
- EXEC_CYC = 40 us
- LONG_CYC = 1640 us
- PWR_CYC = POWERUP_US
- At 25 MHz these are 2 / 12 / 2 / 1000 / 41000 / 1_000_000.
REQ-016 The FSM SHALL have states PWR_WAIT, IDLE, SETUP, PULSE, HOLD and EXEC, plus a 3-bit init index.
REQ-017 After reset, the FSM SHALL sit in PWR_WAIT for PWR_CYC cycles, then issue init bytes (rs=0) 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, each through SETUP->PULSE->HOLD->EXEC.
REQ-018 After the EXEC of 0x06 completes, init_done SHALL go 1 and stay 1 until reset; the FSM then enters IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE with init_done=1.
REQ-020 A request is accepted on a cycle T where req_valid && req_ready.
- req_rs/req_data are captured.
- lcd_rs/lcd_data take the captured values at T+1; the FSM enters SETUP.
REQ-021 SETUP SHALL last SETUP_CYC cycles with lcd_e=0.
- PULSE lasts E_CYC cycles with lcd_e=1.
- HOLD lasts HOLD_CYC cycles with lcd_e=0.
- lcd_rs/lcd_data are stable from SETUP through HOLD.
REQ-022 EXEC SHALL last LONG_CYC cycles when rs=0 and data is 0x01, 0x02 or 0x03; otherwise EXEC_CYC cycles. The FSM then returns to IDLE (or to the next init byte).
REQ-023 lcd_e SHALL be a registered output and glitch-free; it is 1 only in PULSE.
REQ-024 In IDLE, lcd_rs/lcd_data SHALL hold their last driven value.
REQ-025 req_valid while req_ready=0 SHALL be ignored: no capture, and no requirement on the requester to hold it.
REQ-026 Back-to-back requests SHALL produce exactly one E pulse each, with no lost or duplicated bytes.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set all of the following:
- lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00
- req_ready=0, init_done=0
- state=PWR_WAIT, init index=0, timer cleared
REQ-028 Reset asserted mid-operation (including during PULSE) SHALL force lcd_e=0 at that edge and restart the full power-up sequence; the in-flight byte is dropped.

Structure
REQ-029 A shared package lcd_pkg SHALL hold the state enum, the init byte table and the timing constants in ns/us.
REQ-030 A sub-module lcd_delay_counter (loadable down-counter with a done flag, width sized for PWR_CYC) SHALL supply all waits.

Verification (CLK_FREQ_HZ=25_000_000, POWERUP_US=100 so PWR_CYC=2500)
REQ-031 Scenario: hold reset low, then release.
- All outputs are 0 during reset.
- First lcd_e rise comes 2500+2 cycles after release, with lcd_data=0x38, lcd_rs=0.
REQ-032 Scenario: init sequence.
- lcd_e rising edges carry 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- The gap from 0x01 E-fall to 0x06 E-rise is 2+41000+2 cycles.
- init_done and req_ready rise after the final EXEC.
REQ-033 Scenario: send rs=1, data=0x41.
- lcd_rs=1 and lcd_data=0x41 one cycle after acceptance.
- lcd_e is high for exactly 12 cycles.
- req_ready is low for 2+12+2+1000 cycles.
REQ-034 Scenario: two requests with req_valid held continuously (0x48, then 0x49).
- Exactly two E pulses, in order.
- E rising edges are 1017 cycles apart.
REQ-035 Scenario: command rs=0, data=0x02 -> the EXEC wait is 41000 cycles before req_ready returns.
REQ-036 Scenario: pull rst_n low during PULSE.
- lcd_e=0 at the next edge.
- init_done=0.
- After release, the init sequence repeats from 0x38.
